// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin pick helper for the request/grant arbiter
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    localparam int ARB_MAX_N = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Scalar reference form of the pick: first set bit at or after ptr, wrapping mod n_req.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_N-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int                   n_req);
        rr_pick_t   res;
        logic [3:0] c;
        res = '0;
        c   = '0;
        for (int k = ARB_MAX_N - 1; k >= 0; k--) begin
            if (k < n_req) begin
                c = 4'((int'(ptr) + k) % n_req);
                if (req[c]) begin
                    res.found = 1'b1;
                    res.idx   = c;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rtl/rr_pick_n.sv - combinational rotate / priority-encode / un-rotate round-robin picker
module rr_pick_n #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    logic [IW:0]        wrapped;

    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k[IW-1:0];
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign wrapped = (sum >= N_W) ? sum - N_W : sum;
    assign idx     = wrapped[IW-1:0];

endmodule

// File: rtl/rr_req_gnt_arb_prop.sv
// rtl/rr_req_gnt_arb_prop.sv - property module bound to rr_req_gnt_arb: one-hot, req-backed grant, fairness
module rr_req_gnt_arb_prop #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N_REQ-1:0] req,
    input logic [N_REQ-1:0] gnt
);

    localparam int BOUND = (N_REQ - 1) * MAX_HOLD + N_REQ;

    int wait_cnt [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                wait_cnt[i] <= (req[i] && !gnt[i]) ? wait_cnt[i] + 1 : 0;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_backed: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~$past(req)) == '0);

`ifndef ARB_LOCK_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_fair
        a_fair: assert property (@(posedge clk) disable iff (!rst_n) wait_cnt[i] <= BOUND);
    end
`endif

endmodule

// File: rtl/rr_req_gnt_arb.sv
// rtl/rr_req_gnt_arb.sv - N-channel round-robin arbiter with hold limit; optional lock via ARB_LOCK_EN
module rr_req_gnt_arb
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IW       = $clog2(N_REQ),
    localparam int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [IW-1:0]    gnt_id,
    output logic [HW-1:0]    hold_cnt
);

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    arb_state_t       state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IW-1:0]    gnt_id_n;
    logic [HW-1:0]    hold_n;

    logic [N_REQ-1:0] pick_req;
    logic             p_found;
    logic [IW-1:0]    p_idx;
    logic             owner_req;
    logic             lock_hold;
    logic             do_grant;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // The owner sits last in rotation from ptr, so masking it out means a hit is always another channel.
    assign pick_req  = (state == ARB_OWN) ? (req & ~gnt) : req;
    assign owner_req = |(req & gnt);

    rr_pick_n #(.N_REQ(N_REQ)) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .found (p_found),
        .idx   (p_idx)
    );

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        hold_n   = hold_cnt;
        do_grant = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (p_found) do_grant = 1'b1;
            end
            ARB_OWN: begin
                if (!owner_req) begin
                    if (p_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n  = ARB_IDLE;
                        gnt_n    = '0;
                        gnt_id_n = '0;
                        hold_n   = '0;
                    end
                end else if (p_found && (hold_cnt == HOLD_MAX) && !lock_hold) begin
                    do_grant = 1'b1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase

        if (do_grant) begin
            state_n  = ARB_OWN;
            gnt_n    = {{(N_REQ-1){1'b0}}, 1'b1} << p_idx;
            gnt_id_n = p_idx;
            ptr_n    = (p_idx == LAST_ID) ? '0 : p_idx + 1'b1;
            hold_n   = {{(HW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            hold_cnt <= hold_n;
        end
    end

    assign gnt_vld = |gnt;

endmodule
